// File: rtl/watch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | watch_pkg : shared codes for the watch mode/edit sequencer       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_STOPWATCH = 2'd1,
    MODE_TIMER     = 2'd2
  } mode_e;

  localparam logic [3:0] FLAG_RUN    = 4'd0;
  localparam logic [3:0] FLAG_H10    = 4'd3;
  localparam logic [3:0] FLAG_H1     = 4'd4;
  localparam logic [3:0] FLAG_M10    = 4'd5;
  localparam logic [3:0] FLAG_M1     = 4'd6;
  localparam logic [3:0] FLAG_COMMIT = 4'd7;

  localparam int BTN_MODE   = 0;
  localparam int BTN_EDIT   = 1;
  localparam int BTN_CANCEL = 2;
  localparam int BTN_INC    = 3;

  // Encoded so that the state register is directly the flag output.
  typedef enum logic [3:0] {
    S_RUN    = FLAG_RUN,
    S_H10    = FLAG_H10,
    S_H1     = FLAG_H1,
    S_M10    = FLAG_M10,
    S_M1     = FLAG_M1,
    S_COMMIT = FLAG_COMMIT
  } fsm_e;

  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    n = MODE_CLOCK;
    case (m)
      MODE_CLOCK:     n = MODE_STOPWATCH;
      MODE_STOPWATCH: n = MODE_TIMER;
      default:        n = MODE_CLOCK;
    endcase
    return n;
  endfunction

  function automatic fsm_e next_digit(input fsm_e s);
    fsm_e n;
    n = S_RUN;
    case (s)
      S_H10:   n = S_H1;
      S_H1:    n = S_M10;
      S_M10:   n = S_M1;
      S_M1:    n = S_COMMIT;
      default: n = S_RUN;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] digit_onehot(input fsm_e s);
    logic [3:0] oh;
    oh = 4'b0000;
    case (s)
      S_H10:   oh = 4'b0001;
      S_H1:    oh = 4'b0010;
      S_M10:   oh = 4'b0100;
      S_M1:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btn_debounce : 2-flop sync, stability counter, press pulse       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_pressed,
  output logic o_press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level_n;
  logic          r_level_d_n;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_level_n   <= 1'b1;
      r_level_d_n <= 1'b1;
      r_cnt       <= '0;
    end else begin
      r_sync1     <= i_btn_n;
      r_sync2     <= r_sync1;
      r_level_d_n <= r_level_n;
      if (r_sync2 == r_level_n) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        r_level_n <= r_sync2;
        r_cnt     <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Press lasts the one cycle between level acceptance and its delayed copy.
  assign o_pressed = ~r_level_n;
  assign o_press   = r_level_d_n & ~r_level_n;

endmodule
`default_nettype wire

// File: rtl/watch_mode_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | watch_mode_ctrl : button debounce, mode FSM and digit-edit FSM   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 100_000_000,
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter int unsigned REPEAT_CYCLES = 25_000_000,
  parameter int unsigned BLINK_DIV     = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btn,
  output logic [3:0] state,
  output logic [3:0] flag,
  output logic [3:0] inc,
  output logic       load,
  output logic       tick,
  output logic       blink
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  logic [3:0]    w_held;
  logic [3:0]    w_press;
  logic          w_unused_btn;

  fsm_e          r_st;
  mode_e         r_mode;
  logic [3:0]    r_inc;
  logic          r_load;
  logic          r_tick;
  logic          r_blink;
  logic [TW-1:0] r_pre;
  logic [BW-1:0] r_bcnt;
  logic [RW-1:0] r_rep;

  logic          w_pre_wrap;
  logic [TW-1:0] w_pre_next;
  logic          w_bcnt_wrap;
  logic          w_rep_wrap;
  logic          w_inc_evt;
  logic          w_ev_cancel;
  logic          w_ev_edit;
  logic          w_ev_inc;
  logic          w_ev_mode;

  assign w_unused_btn = ^btn[7:4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .i_btn_n  (btn[gi]),
      .o_pressed(w_held[gi]),
      .o_press  (w_press[gi])
    );
  end

  // Auto-repeat: restart on every press, fire each REPEAT_CYCLES while held.
  assign w_rep_wrap = (r_rep == RW'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep <= '0;
    end else if (w_press[BTN_INC] || !w_held[BTN_INC] || w_rep_wrap) begin
      r_rep <= '0;
    end else begin
      r_rep <= r_rep + 1'b1;
    end
  end

  assign w_inc_evt   = w_press[BTN_INC] | (w_held[BTN_INC] & w_rep_wrap);
  assign w_ev_cancel = w_press[BTN_CANCEL];
  assign w_ev_edit   = w_press[BTN_EDIT] & ~w_ev_cancel;
  assign w_ev_inc    = w_inc_evt & ~w_ev_cancel & ~w_ev_edit;
  assign w_ev_mode   = w_press[BTN_MODE] & ~w_ev_cancel & ~w_ev_edit & ~w_inc_evt;

  assign w_pre_wrap  = (r_pre == TW'(TICK_DIV - 1));
  assign w_pre_next  = w_pre_wrap ? '0 : r_pre + 1'b1;
  assign w_bcnt_wrap = (r_bcnt == BW'(BLINK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st    <= S_RUN;
      r_mode  <= MODE_CLOCK;
      r_inc   <= '0;
      r_load  <= 1'b0;
      r_tick  <= 1'b0;
      r_blink <= 1'b1;
      r_pre   <= '0;
      r_bcnt  <= '0;
    end else begin
      r_inc  <= '0;
      r_load <= 1'b0;
      r_tick <= 1'b0;
      case (r_st)
        S_RUN: begin
          r_blink <= 1'b1;
          r_bcnt  <= '0;
          if (w_ev_edit && r_mode == MODE_CLOCK) begin
            r_st  <= S_H10;
            r_pre <= '0;
          end else begin
            r_pre  <= w_pre_next;
            r_tick <= w_pre_wrap;
            if (w_ev_mode) begin
              r_mode <= next_mode(r_mode);
            end
          end
        end
        S_H10, S_H1, S_M10, S_M1: begin
          r_pre <= '0;
          if (w_ev_cancel) begin
            r_st    <= S_RUN;
            r_blink <= 1'b1;
            r_bcnt  <= '0;
          end else if (w_ev_edit) begin
            r_st   <= next_digit(r_st);
            r_bcnt <= '0;
            if (r_st == S_M1) begin
              r_load  <= 1'b1;
              r_blink <= 1'b1;
            end
          end else begin
            if (w_ev_inc) begin
              r_inc <= digit_onehot(r_st);
            end
            if (w_bcnt_wrap) begin
              r_bcnt  <= '0;
              r_blink <= ~r_blink;
            end else begin
              r_bcnt <= r_bcnt + 1'b1;
            end
          end
        end
        // Prescaler starts from zero here so the first tick lands TICK_DIV after load.
        S_COMMIT: begin
          r_st  <= S_RUN;
          r_pre <= w_pre_next;
        end
        default: begin
          r_st <= S_RUN;
        end
      endcase
    end
  end

  assign state = {2'b00, r_mode};
  assign flag  = r_st;
  assign inc   = r_inc;
  assign load  = r_load;
  assign tick  = r_tick;
  assign blink = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_watch_mode_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_watch_mode_ctrl : scoreboard bench for watch_mode_ctrl        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_watch_mode_ctrl;

  localparam int TICK_DIV = 10;
  localparam int DEB      = 4;
  localparam int REP      = 8;
  localparam int BLINK    = 6;

  localparam logic [7:0] M_MODE   = 8'h01;
  localparam logic [7:0] M_EDIT   = 8'h02;
  localparam logic [7:0] M_CANCEL = 8'h04;
  localparam logic [7:0] M_INC    = 8'h08;

  logic       clk;
  logic       rst;
  logic [7:0] btn;
  logic [3:0] state;
  logic [3:0] flag;
  logic [3:0] inc;
  logic       load;
  logic       tick;
  logic       blink;

  watch_mode_ctrl #(
    .TICK_DIV     (TICK_DIV),
    .DEB_CYCLES   (DEB),
    .REPEAT_CYCLES(REP),
    .BLINK_DIV    (BLINK)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .state(state),
    .flag (flag),
    .inc  (inc),
    .load (load),
    .tick (tick),
    .blink(blink)
  );

  typedef struct {
    int         cyc;
    logic [3:0] st;
    logic [3:0] fl;
    logic [3:0] in;
    logic       ld;
    logic       tk;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic       mon_en = 1'b0;
  logic       chk_tick = 1'b0;
  logic [3:0] prev_state;
  logic [3:0] prev_flag;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any strobe or state/flag change must match the next queued item.
  always @(negedge clk) begin
    if (mon_en) begin
      if (flag != 4'd0) begin
        total++;
        if (tick !== 1'b0) begin
          bad++;
          $display("FAIL tick_in_edit cyc=%0d flag=%0d tick=%b want 0", cyc, flag, tick);
        end
      end
      if (inc != 4'd0 || load || (tick && chk_tick) || state != prev_state || flag != prev_flag) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected cyc=%0d st=%0d fl=%0d inc=%b ld=%b tk=%b want no event",
                   cyc, state, flag, inc, load, tick);
        end else begin
          exp_t ee;
          ee = q.pop_front();
          if (ee.cyc != cyc || ee.st !== state || ee.fl !== flag || ee.in !== inc ||
              ee.ld !== load || ee.tk !== (tick & chk_tick)) begin
            bad++;
            $display("FAIL sb_evt got cyc=%0d st=%0d fl=%0d inc=%b ld=%b tk=%b want cyc=%0d st=%0d fl=%0d inc=%b ld=%b tk=%b",
                     cyc, state, flag, inc, load, tick & chk_tick,
                     ee.cyc, ee.st, ee.fl, ee.in, ee.ld, ee.tk);
          end
        end
      end
      prev_state = state;
      prev_flag  = flag;
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_evt(input int c, input logic [3:0] st, input logic [3:0] fl,
                            input logic [3:0] in, input logic ld, input logic tk);
    exp_t ee;
    ee.cyc = c;
    ee.st  = st;
    ee.fl  = fl;
    ee.in  = in;
    ee.ld  = ld;
    ee.tk  = tk;
    q.push_back(ee);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  // First low sample lands on the next edge; buttons are active-low.
  task automatic press(input logic [7:0] mask, input int hold);
    int c0;
    c0  = cyc;
    btn = btn & ~mask;
    goto(c0 + hold);
    btn = btn | mask;
  endtask

  // Accepted press reacts at edge N+2+DEB; gap lets the release settle.
  task automatic press_expect(input logic [7:0] mask, input logic [3:0] st,
                              input logic [3:0] fl, input logic [3:0] in);
    int n;
    n = cyc + 1;
    expect_evt(n + 2 + DEB, st, fl, in, 1'b0, 1'b0);
    press(mask, 6);
    goto(n + 16);
  endtask

  initial begin
    int n;
    int c;
    int e;
    rst = 1'b1;
    btn = 8'hFF;
    goto(3);
    rst = 1'b0;
    check("rst_state", state, 0);
    check("rst_flag", flag, 0);
    check("rst_inc", inc, 0);
    check("rst_load", load, 0);
    check("rst_tick", tick, 0);
    check("rst_blink", blink, 1);
    prev_state = state;
    prev_flag  = flag;
    mon_en     = 1'b1;

    // Idle ticks every TICK_DIV, first 10 cycles after reset release.
    chk_tick = 1'b1;
    for (int k = 1; k <= 4; k++) expect_evt(3 + 10 * k, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    goto(44);
    chk_tick = 1'b0;

    // Glitch then mode presses.
    press(M_MODE, 3);
    goto(cyc + 8);
    check("glitch_state", state, 0);
    press_expect(M_MODE, 4'd1, 4'd0, 4'd0);
    press_expect(M_MODE, 4'd2, 4'd0, 4'd0);
    press_expect(M_MODE, 4'd0, 4'd0, 4'd0);

    // Full edit with one increment per digit, then commit.
    for (int d = 0; d < 4; d++) begin
      press_expect(M_EDIT, 4'd0, 4'(3 + d), 4'd0);
      press_expect(M_INC, 4'd0, 4'(3 + d), 4'(1 << d));
    end
    n = cyc + 1;
    expect_evt(n + 6, 4'd0, 4'd7, 4'd0, 1'b1, 1'b0);
    expect_evt(n + 7, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    expect_evt(n + 16, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    chk_tick = 1'b1;
    press(M_EDIT, 6);
    goto(n + 6);
    check("commit_load", load, 1);
    check("commit_no_inc", inc, 0);
    goto(n + 7);
    check("load_one_cycle", load, 0);
    goto(n + 17);
    chk_tick = 1'b0;

    // Auto-repeat while INC is held in E_M10.
    press_expect(M_EDIT, 4'd0, 4'd3, 4'd0);
    press_expect(M_EDIT, 4'd0, 4'd4, 4'd0);
    press_expect(M_EDIT, 4'd0, 4'd5, 4'd0);
    n = cyc + 1;
    for (int r = 0; r < 4; r++) expect_evt(n + 6 + 8 * r, 4'd0, 4'd5, 4'b0100, 1'b0, 1'b0);
    press(M_INC, 30);
    goto(cyc + 20);

    // Cancel, then CANCEL+INC together in E_H1.
    press_expect(M_CANCEL, 4'd0, 4'd0, 4'd0);
    press_expect(M_EDIT, 4'd0, 4'd3, 4'd0);
    press_expect(M_EDIT, 4'd0, 4'd4, 4'd0);
    press_expect(M_CANCEL | M_INC, 4'd0, 4'd0, 4'd0);
    check("cancel_flag", flag, 0);

    // Reset in E_M1 abandons the edit.
    for (int d = 0; d < 4; d++) press_expect(M_EDIT, 4'd0, 4'(3 + d), 4'd0);
    c = cyc;
    expect_evt(c + 1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    goto(c + 1);
    rst = 1'b0;
    check("mid_rst_flag", flag, 0);
    check("mid_rst_inc", inc, 0);
    check("mid_rst_load", load, 0);
    check("mid_rst_blink", blink, 1);
    goto(cyc + 12);

    // EDIT ignored outside CLOCK; blink cadence in E_H10.
    press_expect(M_MODE, 4'd1, 4'd0, 4'd0);
    press(M_EDIT, 6);
    goto(cyc + 11);
    check("edit_ignored", flag, 0);
    press_expect(M_MODE, 4'd2, 4'd0, 4'd0);
    press_expect(M_MODE, 4'd0, 4'd0, 4'd0);
    check("blink_run", blink, 1);
    n = cyc + 1;
    expect_evt(n + 6, 4'd0, 4'd3, 4'd0, 1'b0, 1'b0);
    press(M_EDIT, 6);
    e = n + 6;
    goto(e);
    check("blink_enter", blink, 1);
    goto(e + 5);
    check("blink_e5", blink, 1);
    goto(e + 6);
    check("blink_e6", blink, 0);
    goto(e + 11);
    check("blink_e11", blink, 0);
    goto(e + 12);
    check("blink_e12", blink, 1);
    press_expect(M_CANCEL, 4'd0, 4'd0, 4'd0);
    check("blink_after_cancel", blink, 1);

    goto(cyc + 5);
    check("sb_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
